pipe_stage_latch: RTL
=====================

Name: pipe_stage_latch

Overview:
Parametrised inter-stage pipeline register, the generic successor to the fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque control bus plus data bus and adds per-stage stall, flush (bubble insertion), valid tracking, edge-detected single-step, EOF halt, a capture counter and a packed debug snapshot for the debug unit. It is instantiated between any two pipeline stages.

Parameters:
NB_DATA, 96, width of opaque data payload (ALU result, operands, PC etc. packed by the instantiator)
NB_CTRL, 8, width of control bit bus
NB_CNT, 16, width of capture counter
HALT_ON_EOF, 1, 1: latch freezes after capturing EOF=1; 0: EOF is only passed through
DBG_SIZE, NB_DATA+NB_CTRL+NB_CNT+4, width of debug snapshot (derived; do not override)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-high reset
i_pipeline_mode  in  2  01: continuous, 11: stepwise, 00/10: hold
i_execute_instruct  in  1  step request (level; rising edge used)
i_stall  in  1  hold current contents on an advance slot
i_flush  in  1  insert bubble on an advance slot
i_valid  in  1  upstream slot holds a real instruction
i_ctrl  in  NB_CTRL  control bits from upstream
i_data  in  NB_DATA  payload from upstream
i_EOF_flag  in  1  end-of-program marker travelling with instruction
o_valid  out  1  registered valid
o_ctrl  out  NB_CTRL  registered control bits
o_data  out  NB_DATA  registered payload
o_EOF_flag  out  1  registered EOF
o_advance  out  1  registered pulse: contents updated on last edge
o_state  out  2  00 HOLD, 01 RUN, 11 STEP, 10 HALT
o_capture_count  out  NB_CNT  number of advance slots taken since reset
o_debug_data  out  DBG_SIZE  {capture_count, state, EOF, valid, ctrl, data}, MSB to LSB

Behaviour:
- Reset (async, immediate): all outputs 0, state HOLD, exec edge register 0, o_debug_data 0.
- Step edge: step_pulse = i_execute_instruct & ~exec_q; exec_q registered every cycle (also in HALT). Held level yields exactly one step.
- State machine (evaluated each edge, HALT sticky until reset):
  - non-HALT: mode 01 -> RUN; mode 11 -> STEP; 00/10 -> HOLD.
  - HALT_ON_EOF=1 and an advance slot captures i_EOF_flag=1 with i_valid=1 and no flush -> HALT (takes priority over mode).
- Advance slot (combinational en): current state RUN and mode 01, or current state STEP and mode 11 and step_pulse. HOLD/HALT: en=0. Mode change takes one edge to reflect in state; during the changeover edge en follows the current state AND new mode (mismatch -> no advance).
- On en edge, priority flush > stall > load:
  - flush: valid<=0, ctrl<=0, data<=0, EOF<=0 (bubble).
  - stall (no flush): all payload registers hold.
  - load: valid, ctrl, data, EOF <= inputs.
  - capture_count increments on load and flush, not on stall; saturates at 2^NB_CNT-1 (no wrap).
  - o_advance<=1 for load or flush, 0 for stall.
- No en: everything holds, o_advance<=0.
- o_debug_data registered alongside payload: same-cycle coherent with o_* outputs.
- HALT_ON_EOF=0: EOF passes through, state never enters HALT.
- Reset mid-step or mid-HALT: returns to HOLD with cleared contents; first post-reset edge with mode 01 enters RUN, next edge advances.

Test Plan:
- Reset, mode 01 for 3 cycles, i_data=0x...A5 valid=1 -> cycle 1 state=01 no advance; cycle 2 o_data=0xA5, o_advance=1, count=1.
- Mode 11, i_execute_instruct held high 5 cycles with changing i_data -> exactly one capture, count increments by 1; release and re-press -> one more capture.
- Mode 01, i_stall=1 for 2 cycles, then i_flush=1 and i_stall=1 same cycle -> contents held 2 cycles, count unchanged, o_advance=0; then valid=0, ctrl=0, data=0, count+1.
- HALT_ON_EOF=1, load i_EOF_flag=1 valid=1 -> o_EOF_flag=1, state=10 next edge, further inputs ignored; assert i_reset -> all zero immediately, state 00.
- NB_CNT=3, 10 loads in mode 01 -> count stops at 7.
- Mode toggles 01->00->01 mid-stream -> no captures while state HOLD, o_debug_data equals {count,state,EOF,valid,ctrl,data} every cycle.

Source files
------------

// File: rtl/pipe_stage_latch.sv
// Generic inter-stage pipeline register: opaque ctrl/data payload with stall,
// flush, edge-detected single-step, EOF halt, capture counter and debug snapshot.
module pipe_stage_latch #(
  parameter int NB_DATA     = 96,
  parameter int NB_CTRL     = 8,
  parameter int NB_CNT      = 16,
  parameter int HALT_ON_EOF = 1,
  parameter int DBG_SIZE    = NB_DATA + NB_CTRL + NB_CNT + 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [1:0]          i_pipeline_mode,
  input  logic                i_execute_instruct,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [NB_CTRL-1:0]  i_ctrl,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic                i_EOF_flag,
  output logic                o_valid,
  output logic [NB_CTRL-1:0]  o_ctrl,
  output logic [NB_DATA-1:0]  o_data,
  output logic                o_EOF_flag,
  output logic                o_advance,
  output logic [1:0]          o_state,
  output logic [NB_CNT-1:0]   o_capture_count,
  output logic [DBG_SIZE-1:0] o_debug_data
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b11,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b11;

  state_t              state_q, state_d;
  logic                exec_q;
  logic                valid_q, valid_d;
  logic [NB_CTRL-1:0]  ctrl_q, ctrl_d;
  logic [NB_DATA-1:0]  data_q, data_d;
  logic                eof_q, eof_d;
  logic [NB_CNT-1:0]   count_q, count_d;
  logic                advance_q;
  logic [DBG_SIZE-1:0] debug_q;

  logic step_pulse;
  logic en;
  logic do_flush;
  logic do_load;

  // The advance slot uses the registered state with the live mode, so a mode
  // change costs one edge before captures resume.
  always_comb begin
    step_pulse = i_execute_instruct & ~exec_q;
    en         = ((state_q == ST_RUN)  && (i_pipeline_mode == MODE_RUN)) ||
                 ((state_q == ST_STEP) && (i_pipeline_mode == MODE_STEP) && step_pulse);
    do_flush   = en & i_flush;
    do_load    = en & ~i_flush & ~i_stall;
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    eof_d   = eof_q;
    count_d = count_q;
    if (do_flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
      eof_d   = 1'b0;
    end else if (do_load) begin
      valid_d = i_valid;
      ctrl_d  = i_ctrl;
      data_d  = i_data;
      eof_d   = i_EOF_flag;
    end
    if ((do_flush || do_load) && (count_q != {NB_CNT{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != ST_HALT) begin
      if ((HALT_ON_EOF != 0) && do_load && i_valid && i_EOF_flag)
        state_d = ST_HALT;
      else begin
        case (i_pipeline_mode)
          MODE_RUN:  state_d = ST_RUN;
          MODE_STEP: state_d = ST_STEP;
          default:   state_d = ST_HOLD;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_HOLD;
      exec_q    <= 1'b0;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      data_q    <= '0;
      eof_q     <= 1'b0;
      count_q   <= '0;
      advance_q <= 1'b0;
      debug_q   <= '0;
    end else begin
      state_q   <= state_d;
      exec_q    <= i_execute_instruct;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      eof_q     <= eof_d;
      count_q   <= count_d;
      advance_q <= do_flush | do_load;
      debug_q   <= {count_d, state_d, eof_d, valid_d, ctrl_d, data_d};
    end
  end

  assign o_valid         = valid_q;
  assign o_ctrl          = ctrl_q;
  assign o_data          = data_q;
  assign o_EOF_flag      = eof_q;
  assign o_advance       = advance_q;
  assign o_state         = state_q;
  assign o_capture_count = count_q;
  assign o_debug_data    = debug_q;

endmodule
